// File: rtl/spmv_colidx_fetch_if.sv
// AXI read-address/read-data channels plus the AXI-Stream output of the
// column-index fetcher, bundled so the fetcher and its neighbours share one port.
interface spmv_colidx_fetch_if #(
    parameter int ADDR_WIDTH = 48,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 1
);
    logic [ID_WIDTH-1:0]   m_axi_arid;
    logic [ADDR_WIDTH-1:0] m_axi_araddr;
    logic [7:0]            m_axi_arlen;
    logic [2:0]            m_axi_arsize;
    logic [1:0]            m_axi_arburst;
    logic                  m_axi_arvalid;
    logic                  m_axi_arready;

    logic [ID_WIDTH-1:0]   m_axi_rid;
    logic [DATA_WIDTH-1:0] m_axi_rdata;
    logic [1:0]            m_axi_rresp;
    logic                  m_axi_rlast;
    logic                  m_axi_rvalid;
    logic                  m_axi_rready;

    logic [DATA_WIDTH-1:0] m_axis_tdata;
    logic                  m_axis_tvalid;
    logic                  m_axis_tready;
    logic                  m_axis_tlast;

    modport master (
        output m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid,
        input  m_axi_arready,
        input  m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
        output m_axi_rready,
        output m_axis_tdata, m_axis_tvalid, m_axis_tlast,
        input  m_axis_tready
    );

    modport slave (
        input  m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid,
        output m_axi_arready,
        output m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
        input  m_axi_rready,
        input  m_axis_tdata, m_axis_tvalid, m_axis_tlast,
        output m_axis_tready
    );
endinterface

// File: rtl/spmv_colidx_fetch.sv
// Column-index fetcher: walks a 4-byte element array with single-beat AXI reads,
// bounded in flight, and streams the returned indices in order with tlast.
module spmv_colidx_fetch #(
    parameter int ADDR_WIDTH      = 48,
    parameter int DATA_WIDTH      = 32,
    parameter int ID_WIDTH        = 1,
    parameter int MAX_OUTSTANDING = 8,
    parameter int CNT_WIDTH       = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [CNT_WIDTH-1:0]  count,
    output logic                  busy,
    output logic                  done,
    output logic                  err_resp,
    spmv_colidx_fetch_if.master   bus
);
    localparam int OUT_W = $clog2(MAX_OUTSTANDING) + 1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;
    localparam logic [OUT_W-1:0]     OUT_ONE = 1;
    localparam logic [OUT_W-1:0]     OUT_MAX = OUT_W'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t                state_reg, state_next;
    logic [ADDR_WIDTH-1:0] base_reg;
    logic [CNT_WIDTH-1:0]  count_reg;
    logic [CNT_WIDTH-1:0]  issued_reg;
    logic [CNT_WIDTH-1:0]  returned_reg;
    logic [OUT_W-1:0]      outstanding_reg;
    logic [DATA_WIDTH-1:0] tdata_reg;
    logic                  tvalid_reg;
    logic                  tlast_reg;
    logic                  err_reg;

    logic job_active, start_ok, can_issue;
    logic arvalid, rready;
    logic ar_hs, r_hs, t_hs;
    logic unused_r;

    assign job_active = (state_reg == ISSUE) || (state_reg == DRAIN);
    assign start_ok   = (state_reg == IDLE) && start;
    assign can_issue  = outstanding_reg < OUT_MAX;
    assign ar_hs      = arvalid & bus.m_axi_arready;
    // Beats taken while no job is running are swallowed, not forwarded.
    assign r_hs       = job_active & bus.m_axi_rvalid & rready;
    assign t_hs       = tvalid_reg & bus.m_axis_tready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = (count == '0) ? DONE : ISSUE;
            ISSUE:   if (ar_hs && (issued_reg == count_reg - CNT_ONE)) state_next = DRAIN;
            DRAIN:   if (t_hs && tlast_reg) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // arvalid only depends on state and the in-flight count, and the count
    // cannot rise without an AR handshake, so a raised arvalid stays raised.
    always_comb begin
        busy    = 1'b0;
        done    = 1'b0;
        arvalid = 1'b0;
        rready  = 1'b1;
        case (state_reg)
            ISSUE: begin
                busy    = 1'b1;
                arvalid = can_issue;
                rready  = ~tvalid_reg | bus.m_axis_tready;
            end
            DRAIN: begin
                busy   = 1'b1;
                rready = ~tvalid_reg | bus.m_axis_tready;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_reg        <= '0;
            count_reg       <= '0;
            issued_reg      <= '0;
            returned_reg    <= '0;
            outstanding_reg <= '0;
            tdata_reg       <= '0;
            tvalid_reg      <= 1'b0;
            tlast_reg       <= 1'b0;
            err_reg         <= 1'b0;
        end else begin
            if (start_ok) begin
                base_reg     <= base_addr;
                count_reg    <= count;
                issued_reg   <= '0;
                returned_reg <= '0;
                err_reg      <= 1'b0;
            end else begin
                if (ar_hs) issued_reg <= issued_reg + CNT_ONE;
                if (r_hs) begin
                    returned_reg <= returned_reg + CNT_ONE;
                    if (bus.m_axi_rresp != 2'b00) err_reg <= 1'b1;
                end
            end

            case ({ar_hs, r_hs})
                2'b10:   outstanding_reg <= outstanding_reg + OUT_ONE;
                2'b01:   outstanding_reg <= outstanding_reg - OUT_ONE;
                default: ;
            endcase

            if (r_hs) begin
                tdata_reg  <= bus.m_axi_rdata;
                tvalid_reg <= 1'b1;
                tlast_reg  <= (returned_reg == count_reg - CNT_ONE);
            end else if (bus.m_axis_tready) begin
                tvalid_reg <= 1'b0;
                tlast_reg  <= 1'b0;
            end
        end
    end

    assign err_resp          = err_reg;
    assign bus.m_axi_arid    = '0;
    assign bus.m_axi_araddr  = base_reg + ADDR_WIDTH'({issued_reg, 2'b00});
    assign bus.m_axi_arlen   = 8'd0;
    assign bus.m_axi_arsize  = 3'b010;
    assign bus.m_axi_arburst = 2'b01;
    assign bus.m_axi_arvalid = arvalid;
    assign bus.m_axi_rready  = rready;
    assign bus.m_axis_tdata  = tdata_reg;
    assign bus.m_axis_tvalid = tvalid_reg;
    assign bus.m_axis_tlast  = tlast_reg;

    assign unused_r = ^{bus.m_axi_rid, bus.m_axi_rlast};
endmodule
